// File: rtl/sio_pkg.sv
// Shared definitions for the SIO host-link command scheduler.
//   - Default frame length of the host link.
//   - Field layout of the 80-bit command word sent on wdata:
//       wdata = {we, 3'b000, addr[11:0], data[63:0]}
//   - Command struct as held in the FIFO and the issue register.
//   - Scheduler FSM state encoding.
//   - pack_wdata(): builds the 80-bit link word from a command.
package sio_pkg;

    localparam int FRAME_LEN_DEF = 64;

    localparam int WDATA_W  = 80;
    localparam int WE_BIT   = 79;
    localparam int ADDR_LSB = 64;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 64;
    localparam int RDATA_W  = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Bits 78:76 are reserved and always sent as zero.
    function automatic logic [WDATA_W-1:0] pack_wdata(input cmd_t cmd);
        logic [WDATA_W-1:0] word;
        word                     = '0;
        word[WE_BIT]             = cmd.we;
        word[ADDR_LSB +: ADDR_W] = cmd.addr;
        word[DATA_W-1:0]         = cmd.data;
        return word;
    endfunction

endpackage

// File: rtl/sio_cmd_fifo.sv
// Synchronous command FIFO (single clock, show-ahead read).
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (empties the FIFO)
//   push      in   write request; ignored while full
//   push_data in   entry to write
//   full      out  no free entry
//   pop       in   read request; ignored while empty
//   pop_data  out  head entry, valid whenever empty=0
//   empty     out  no stored entry
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter; DEPTH must be a power of two.
module sio_cmd_fifo #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sio_cmd_sched.sv
// Upstream command scheduler for the SIO host link.
// Queues host register commands, generates the frame sync, issues at most one
// command per frame on wvalid/wdata, and matches each command to its
// rvalid/rdata response. A missing response times out and is reissued up to
// MAX_RETRY times before being reported with resp_err. One command is
// outstanding at a time.
//   c           in   system clock
//   rstn        in   asynchronous active-low reset
//   cmd_valid   in   command offered; accepted when cmd_ready=1
//   cmd_ready   out  command FIFO not full
//   cmd_we      in   1 = write, 0 = read
//   cmd_addr    in   remote register address
//   cmd_data    in   write data (ignored for reads)
//   cmd_tag     in   opaque tag returned on resp_tag
//   sync        out  frame sync, one cycle per frame at the last frame cycle
//   wvalid      out  command strobe, only at the second-to-last frame cycle
//   wdata       out  {we, 3'b000, addr, data}; holds its last value otherwise
//   rvalid      in   CRC-checked response from the link
//   rdata       in   read data, valid with rvalid
//   resp_valid  out  one-cycle completion pulse, no backpressure
//   resp_err    out  retries exhausted (resp_data is then 0)
//   resp_data   out  read data, 0 for writes
//   resp_tag    out  tag of the completed command
//   retry_count out  total reissues, saturating
module sio_cmd_sched
    import sio_pkg::*;
#(
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int DEPTH       = 16,
    parameter int TAG_W       = 4,
    parameter int RESP_FRAMES = 2,
    parameter int MAX_RETRY   = 3
) (
    input  logic               c,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_data,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic               sync,
    output logic               wvalid,
    output logic [WDATA_W-1:0] wdata,
    input  logic               rvalid,
    input  logic [RDATA_W-1:0] rdata,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [RDATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]   resp_tag,
    output logic [15:0]        retry_count
);

    localparam int FC_W    = $clog2(FRAME_LEN);
    localparam int CNT_W   = $clog2(RESP_FRAMES + 2);
    localparam int TRY_W   = $clog2(MAX_RETRY + 1);
    localparam int ENTRY_W = $bits(cmd_t) + TAG_W;

    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAME_LEN - 1);
    localparam logic [FC_W-1:0] FC_ISSUE = FC_W'(FRAME_LEN - 2);

    // ---------------------------------------------------------------- FIFO
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_rd;
    cmd_t               fifo_cmd;
    logic [TAG_W-1:0]   fifo_tag;

    assign {fifo_cmd, fifo_tag} = fifo_rd;
    assign cmd_ready            = !fifo_full;

    sio_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (c),
        .rst_n     (rstn),
        .push      (cmd_valid),
        .push_data ({cmd_we, cmd_addr, cmd_data, cmd_tag}),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------ state
    state_t             state_q,       state_d;
    logic [FC_W-1:0]    fc_q,          fc_d;
    logic               sync_q,        sync_d;
    logic               wvalid_q,      wvalid_d;
    logic [WDATA_W-1:0] wdata_q,       wdata_d;
    cmd_t               cmd_q,         cmd_d;
    logic [TAG_W-1:0]   tag_q,         tag_d;
    logic [CNT_W-1:0]   sync_cnt_q,    sync_cnt_d;
    logic [TRY_W-1:0]   tries_q,       tries_d;
    logic [15:0]        retry_count_q, retry_count_d;
    logic               resp_valid_q,  resp_valid_d;
    logic               resp_err_q,    resp_err_d;
    logic [RDATA_W-1:0] resp_data_q,   resp_data_d;
    logic [TAG_W-1:0]   resp_tag_q,    resp_tag_d;

    always_comb begin
        // Outputs are registered, so decisions look at the frame count of the
        // *next* cycle: sync and wvalid then appear exactly at FRAME_LEN-1 and
        // FRAME_LEN-2 on the flop outputs.
        fc_d   = (fc_q == FC_LAST) ? '0 : fc_q + FC_W'(1);
        sync_d = (fc_d == FC_LAST);

        state_d       = state_q;
        wvalid_d      = 1'b0;
        wdata_d       = wdata_q;
        cmd_d         = cmd_q;
        tag_d         = tag_q;
        sync_cnt_d    = sync_cnt_q;
        tries_d       = tries_q;
        retry_count_d = retry_count_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = resp_err_q;
        resp_data_d   = resp_data_q;
        resp_tag_d    = resp_tag_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_cmd;
                    tag_d    = fifo_tag;
                    tries_d  = '0;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // A retry lands here too; cmd_q is untouched, so the reissued
                // word is bit-identical to the first one.
                if (fc_d == FC_ISSUE) begin
                    wvalid_d   = 1'b1;
                    wdata_d    = pack_wdata(cmd_q);
                    sync_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (sync_q) sync_cnt_d = sync_cnt_q + CNT_W'(1);
                // A response arriving on the timeout cycle still counts.
                if (rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = cmd_q.we ? '0 : rdata;
                    resp_tag_d   = tag_q;
                    state_d      = ST_IDLE;
                end else if (sync_q && (sync_cnt_q == CNT_W'(RESP_FRAMES))) begin
                    // This sync takes the count to RESP_FRAMES+1: timed out.
                    if (tries_q < TRY_W'(MAX_RETRY)) begin
                        tries_d = tries_q + TRY_W'(1);
                        if (retry_count_q != '1) retry_count_d = retry_count_q + 16'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                        resp_tag_d   = tag_q;
                        state_d      = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge c or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            fc_q          <= '0;
            sync_q        <= 1'b0;
            wvalid_q      <= 1'b0;
            wdata_q       <= '0;
            cmd_q         <= '0;
            tag_q         <= '0;
            sync_cnt_q    <= '0;
            tries_q       <= '0;
            retry_count_q <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_data_q   <= '0;
            resp_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            fc_q          <= fc_d;
            sync_q        <= sync_d;
            wvalid_q      <= wvalid_d;
            wdata_q       <= wdata_d;
            cmd_q         <= cmd_d;
            tag_q         <= tag_d;
            sync_cnt_q    <= sync_cnt_d;
            tries_q       <= tries_d;
            retry_count_q <= retry_count_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_data_q   <= resp_data_d;
            resp_tag_q    <= resp_tag_d;
        end
    end

    assign sync        = sync_q;
    assign wvalid      = wvalid_q;
    assign wdata       = wdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_data   = resp_data_q;
    assign resp_tag    = resp_tag_q;
    assign retry_count = retry_count_q;

endmodule

// File: tb/tb_sio_cmd_sched.sv
// Directed bench for sio_cmd_sched with a host-link model (rvalid 70 cycles
// after each wvalid, optional dropping of the next N responses) and a
// scoreboard of expected responses filled at command acceptance.
module tb_sio_cmd_sched;
    import sio_pkg::*;

    localparam int TAG_W     = 4;
    localparam int FRAME_LEN = 64;
    localparam int LINK_LAT  = 70;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_we;
    logic [11:0]        cmd_addr;
    logic [63:0]        cmd_data;
    logic [TAG_W-1:0]   cmd_tag;
    logic               sync;
    logic               wvalid;
    logic [79:0]        wdata;
    logic               rvalid;
    logic [31:0]        rdata;
    logic               resp_valid;
    logic               resp_err;
    logic [31:0]        resp_data;
    logic [TAG_W-1:0]   resp_tag;
    logic [15:0]        retry_count;

    always #5 clk = ~clk;

    sio_cmd_sched #(
        .FRAME_LEN   (FRAME_LEN),
        .DEPTH       (16),
        .TAG_W       (TAG_W),
        .RESP_FRAMES (2),
        .MAX_RETRY   (3)
    ) dut (
        .c           (clk),
        .rstn        (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_tag     (cmd_tag),
        .sync        (sync),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_data   (resp_data),
        .resp_tag    (resp_tag),
        .retry_count (retry_count)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [31:0]      data;
    } exp_t;

    exp_t        sb[$];
    logic [79:0] wlog[$];
    int          total    = 0;
    int          bad      = 0;
    int          tb_fc    = 0;
    int          resp_cnt = 0;
    int          rv_fired = 0;
    int          drop_n   = 0;

    task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] link_rdata(input logic [11:0] addr);
        if (addr == 12'h010) return 32'hDEADBEEF;
        return {20'hC0FFE, addr};
    endfunction

    function automatic logic [79:0] exp_word(input logic we, input logic [11:0] addr,
                                             input logic [63:0] data);
        return {we, 3'b000, addr, data};
    endfunction

    // Link model: answers each wvalid LINK_LAT cycles later unless dropped.
    // A pending answer survives DUT reset, which yields a stray rvalid.
    initial begin : link_model
        bit          pend;
        int          cd;
        logic [31:0] pend_rdata;
        pend   = 1'b0;
        cd     = 0;
        rvalid = 1'b0;
        rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend   = 1'b0;
                    rvalid = 1'b1;
                    rdata  = pend_rdata;
                    rv_fired++;
                end
            end
            if (rst_n && wvalid) begin
                wlog.push_back(wdata);
                if (drop_n > 0) begin
                    drop_n--;
                end else begin
                    pend       = 1'b1;
                    cd         = LINK_LAT;
                    pend_rdata = link_rdata(wdata[75:64]);
                end
            end
        end
    end

    // Frame model, sync/wvalid timing checks and scoreboard comparison.
    initial begin : monitor
        bit   in_rst;
        exp_t e;
        forever begin
            @(posedge clk);
            in_rst = !rst_n;
            tb_fc  = in_rst ? 0 : ((tb_fc == FRAME_LEN - 1) ? 0 : tb_fc + 1);
            #1;
            if (!in_rst && rst_n) begin
                check("sync", 80'(sync), 80'(tb_fc == FRAME_LEN - 1));
                if (wvalid) check("wvalid_fc", 80'(tb_fc), 80'(FRAME_LEN - 2));
                if (resp_valid) begin
                    resp_cnt++;
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 80'(resp_valid), 80'(1'b0));
                    end else begin
                        e = sb.pop_front();
                        check("resp_tag",  80'(resp_tag),  80'(e.tag));
                        check("resp_err",  80'(resp_err),  80'(e.err));
                        check("resp_data", 80'(resp_data), 80'(e.data));
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic we, input logic [11:0] addr, input logic [63:0] data,
                            input logic [TAG_W-1:0] tag, input logic exp_err, output int stall);
        exp_t e;
        stall     = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_tag   = tag;
        while (!cmd_ready && stall < 1000) begin
            @(posedge clk);
            #1;
            stall++;
        end
        check("push_ready", 80'(cmd_ready), 80'(1'b1));
        if (cmd_ready) begin
            e.tag  = tag;
            e.err  = exp_err;
            e.data = (exp_err || we) ? 32'h0 : link_rdata(addr);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 80'(sb.size()), 80'(0));
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_sync"},        80'(sync),        80'(0));
        check({pfx, "_wvalid"},      80'(wvalid),      80'(0));
        check({pfx, "_wdata"},       wdata,            80'(0));
        check({pfx, "_resp_valid"},  80'(resp_valid),  80'(0));
        check({pfx, "_resp_err"},    80'(resp_err),    80'(0));
        check({pfx, "_resp_data"},   80'(resp_data),   80'(0));
        check({pfx, "_resp_tag"},    80'(resp_tag),    80'(0));
        check({pfx, "_retry_count"}, 80'(retry_count), 80'(0));
        check({pfx, "_cmd_ready"},   80'(cmd_ready),   80'(1));
    endtask

    initial begin : stimulus
        int          st;
        int          first_stall;
        int          rv0;
        int          resp0;
        int          wl0;
        int          n;
        logic [79:0] w;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_tag   = '0;

        // Reset state
        wait_cycles(3);
        check_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: single read
        wlog.delete();
        push_cmd(1'b0, 12'h010, 64'h0, 4'd5, 1'b0, st);
        wait_drain("t1_drain", 400);
        check("t1_wv_count", 80'(wlog.size()), 80'(1));
        w = (wlog.size() > 0) ? wlog[0] : '1;
        check("t1_we_bit", 80'(w[79]), 80'(1'b0));
        check("t1_addr",   80'(w[75:64]), 80'(12'h010));

        // 2: single write; link returns non-zero rdata which must be masked
        wlog.delete();
        push_cmd(1'b1, 12'h001, 64'h0000_0000_0000_0145, 4'd3, 1'b0, st);
        wait_drain("t2_drain", 400);
        check("t2_wv_count", 80'(wlog.size()), 80'(1));
        w = (wlog.size() > 0) ? wlog[0] : '1;
        check("t2_wdata", w, exp_word(1'b1, 12'h001, 64'h145));

        // 3: 20 back-to-back commands; 16 stored plus one popped before stall
        wlog.delete();
        first_stall = -1;
        for (int i = 0; i < 20; i++) begin
            push_cmd(1'b0, 12'h100 + 12'(i), 64'(i), 4'(i), 1'b0, st);
            if (st > 0 && first_stall < 0) first_stall = i;
        end
        check("t3_first_stall", 80'(first_stall), 80'(17));
        wait_drain("t3_drain", 4000);
        check("t3_wv_count", 80'(wlog.size()), 80'(20));

        // 4: first two answers dropped -> two retries, identical words
        wlog.delete();
        drop_n = 2;
        push_cmd(1'b0, 12'h044, 64'h1234, 4'd6, 1'b0, st);
        wait_drain("t4_drain", 1000);
        check("t4_retry_count", 80'(retry_count), 80'(2));
        check("t4_wv_count", 80'(wlog.size()), 80'(3));
        foreach (wlog[i]) check("t4_same_word", wlog[i], exp_word(1'b0, 12'h044, 64'h1234));

        // 5: all four attempts dropped -> error; next command completes normally
        wlog.delete();
        drop_n = 4;
        push_cmd(1'b0, 12'h055, 64'h0, 4'd7, 1'b1, st);
        push_cmd(1'b0, 12'h066, 64'h0, 4'd9, 1'b0, st);
        wait_drain("t5_drain", 3000);
        check("t5_retry_count", 80'(retry_count), 80'(5));
        check("t5_wv_count", 80'(wlog.size()), 80'(5));
        check("t5_drops_used", 80'(drop_n), 80'(0));
        w = (wlog.size() > 3) ? wlog[3] : '1;
        check("t5_last_retry_word", w, exp_word(1'b0, 12'h055, 64'h0));

        // 6: reset while waiting with three more queued
        wlog.delete();
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 12'h200 + 12'(i), 64'h0, 4'(8 + i), 1'b0, st);
        n = 0;
        while (wlog.size() == 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_issued", 80'(wlog.size()), 80'(1));
        wait_cycles(3);
        resp0 = resp_cnt;
        rv0   = rv_fired;
        wl0   = wlog.size();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        wait_cycles(2);
        check_idle_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (rv_fired == rv0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_stray_sent", 80'(rv_fired - rv0), 80'(1));
        wait_cycles(20);
        check("t6_no_resp", 80'(resp_cnt - resp0), 80'(0));
        check("t6_no_reissue", 80'(wlog.size() - wl0), 80'(0));
        check("t6_retry_cleared", 80'(retry_count), 80'(0));

        // Scheduler still usable after the reset
        push_cmd(1'b0, 12'h3AB, 64'h0, 4'd12, 1'b0, st);
        wait_drain("t6_post_drain", 400);
        check("t6_post_resp", 80'(resp_cnt - resp0), 80'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
